pc_fetch_unit: RTL



---
 rtl/pc_fetch_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// PC register, instruction fetch/latch and data-memory sequencing for the single-cycle core.
// Optional retired-instruction counter enabled by defining PC_FETCH_RETIRE_CNT_EN.
module pc_fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  PCSrc,
    input  logic        Halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [15:0] imm,
    input  logic [25:0] addr,
    input  logic [31:0] rs_data,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        dhit,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] Instr,
    output logic        instr_valid,
    output logic        dmem_req,
    output logic [31:0] pc_plus4,
    output logic        halt,
`ifdef PC_FETCH_RETIRE_CNT_EN
    output logic [31:0] retire_cnt,
`endif
    output logic [1:0]  state_dbg
);

    // Handshakes: imemREN is held until ihit; dmem_req is held until dhit.
    // A request is considered accepted on the rising edge where its hit is high.
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        MEM    = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] instr_q;
    logic [31:0] next_pc;
    logic [31:0] branch_off;
    logic        mem_op;
    logic        pc_update;

    always_comb begin
        mem_op     = dmemREN | dmemWEN;
        pc_plus4   = pc + 32'd4;
        branch_off = {{14{imm[15]}}, imm, 2'b00};
        next_pc    = pc_plus4;
        case (PCSrc)
            2'd0:    next_pc = pc_plus4;
            2'd1:    next_pc = pc_plus4 + branch_off;
            2'd2:    next_pc = {pc_plus4[31:28], addr, 2'b00};
            2'd3:    next_pc = rs_data;
            default: next_pc = pc_plus4;
        endcase
    end

    // The PC moves only when the current instruction completes; Halt takes priority.
    always_comb begin
        pc_update = 1'b0;
        if (state == EXEC)
            pc_update = !Halt && (!mem_op || dhit);
        else if (state == MEM)
            pc_update = dhit;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= FETCH;
            pc      <= PC_INIT;
            instr_q <= 32'd0;
        end else begin
            if (pc_update)
                pc <= next_pc;
            case (state)
                FETCH: begin
                    if (ihit) begin
                        instr_q <= imemload;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (Halt)
                        state <= HALTED;
                    else if (mem_op && !dhit)
                        state <= MEM;
                    else
                        state <= FETCH;
                end
                MEM: begin
                    if (dhit)
                        state <= FETCH;
                end
                HALTED:  state <= HALTED;
                default: state <= FETCH;
            endcase
        end
    end

    // Outputs decode the registered state, so reset clears them asynchronously.
    always_comb begin
        imemREN     = (state == FETCH) && !RST;
        instr_valid = (state == EXEC) || (state == MEM);
        dmem_req    = mem_op && (((state == EXEC) && !Halt) || (state == MEM));
        halt        = (state == HALTED);
        imemaddr    = pc;
        Instr       = instr_q;
        state_dbg   = state;
    end

`ifdef PC_FETCH_RETIRE_CNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            retire_cnt <= 32'd0;
        else if (pc_update)
            retire_cnt <= retire_cnt + 32'd1;
    end
`endif

endmodule
